maxpool_32_2_16: RTL and testbench
==================================

# maxpool_32_2_16

Streaming 1-D max-pooling stage placed directly downstream of the convolution blocks (`conv_N_M_T_P`). It consumes the ReLU'd convolution output stream of `L` signed samples per vector and reduces each window of `K` consecutive samples to its maximum. Results are emitted through a 2-entry output FIFO with a per-vector `y_last` marker. Both sides use a valid/ready handshake, so the block drops between the convolution stage and the next layer without extra glue.

## Interface
- `L`, 32, samples per input vector (convolution output length N-M+1); L ≥ 1
- `K`, 2, pooling window and stride; 1 ≤ K ≤ L
- `T`, 16, sample width, signed two's complement
- `clk`  input  1  clock; all state changes on the rising edge
- `reset`  input  1  asynchronous, active-high reset
- `x_data`  input  T  signed input sample
- `x_valid`  input  1  `x_data` is valid
- `x_ready`  output  1  block accepts a sample this cycle
- `y_data`  output  T  signed pooled maximum at the FIFO head
- `y_valid`  output  1  FIFO head is valid
- `y_ready`  input  1  consumer accepts the FIFO head
- `y_last`  output  1  FIFO head is the last pooled value of its vector

## Operation
- An input is accepted on a cycle where `x_valid && x_ready`. An output is popped on a cycle where `y_valid && y_ready`.
- Counters:
  - `elem_cnt` runs 0..L-1 and wraps to 0 after L-1.
  - `win_cnt` runs 0..K-1 and wraps to 0 after K-1. It is also forced to 0 when `elem_cnt` wraps.
- Running max register `run_max`:
  - On an accept with `win_cnt==0`, load `run_max` with `x_data`. It is never seeded with 0.
  - Otherwise, update `run_max` to max(`run_max`, `x_data`) using a signed compare.
- Window close: a window closes on an accept where `win_cnt==K-1` or `elem_cnt==L-1`.
  - On close, push the value max(`run_max`, `x_data`) into the FIFO (just `x_data` if `win_cnt==0`).
  - The pushed entry's `last` bit equals (`elem_cnt==L-1`).
- Partial window: if L mod K ≠ 0, the final window of a vector holds L mod K samples and is still emitted. Outputs per vector = ceil(L/K).
- No arithmetic is performed beyond compare and select. Widths are preserved, with no saturation or truncation.
- Output FIFO:
  - 2 entries, each holding {last, data}. A 2-bit count tracks occupancy (0..2).
  - `x_ready` = (count < 2). This is conservative: `x_ready` stays low whenever the FIFO is full, even if a pop happens in the same cycle.
  - Simultaneous push and pop at count 1 leaves count at 1 and data stays ordered (FIFO).
  - A push is never attempted at count 2, because `x_ready` is low then.
- Datapath state machine:
  - IDLE: no accept this cycle.
  - ACCUM: an accept that does not close a window.
  - EMIT: an accept that closes a window.
  - Transitions follow from each cycle's accept and the counters. The state is observable only through the counters and `run_max`.
- Pops do not affect the counters. A pop at count 0 is impossible, because `y_valid` is low then.

## Timing
- Reset (asynchronous, takes effect immediately): count=0, `elem_cnt`=0, `win_cnt`=0, `run_max`=0, FIFO storage=0.
- While `reset` is high, the outputs are `y_valid`=0, `y_data`=0, `y_last`=0 and `x_ready`=0.
- `x_ready` rises combinationally once `reset` deasserts, since count=0.
- Latency: the window-closing sample is accepted at edge n, and `y_valid` is high (with the result at the head) from edge n+1.
- Throughput: one sample per cycle while `y_ready` is held high.
- `y_data` and `y_last` hold stable while `y_valid && !y_ready`.
- Reset asserted mid-vector discards the partial window and all FIFO contents. The next accepted sample is element 0 of a new vector.
- `x_valid` may toggle freely. Gaps inside a window do not alter the result.

## Test plan
- L=32, K=2, T=16: stream x[i]=i with `y_ready`=1 -> 16 outputs 1,3,5,…,31; `y_last` high only on 31; one output per 2 input cycles, first `y_valid` the cycle after the 2nd accept.
- Signed compare with K=2: inputs -5,-3, 0x8000,0x7FFF, -1,0 -> outputs -3, 0x7FFF, 0; run_max never takes 0 for an all-negative window.
- Back-pressure with `y_ready`=0 and a continuous stream: after 4 accepts, 2 entries are held and `x_ready`=0. Raise `y_ready` for one cycle -> one pop, and `x_ready` returns high the following cycle. No sample is lost or duplicated across the full 32-sample vector.
- L=5, K=2 partial window: inputs 4,9,2,7,6 -> outputs 9,7,6 with `y_last` on 6. A second vector 1,1,1,1,8 -> 1,1,8, confirming the counters re-align at the vector boundary.
- Assert `reset` asynchronously mid-window (after 1 sample of a K=2 window, with the FIFO holding 1 entry) -> `y_valid` drops immediately. Post-reset inputs 10,20 -> single output 20, not influenced by the pre-reset sample.
- Random `x_valid` and `y_ready` at 50% over 10 vectors (L=32, K=2) -> output sequence matches the reference model exactly, with `y_last` every 16th output.

Source files
------------

// File: rtl/maxpool_32_2_16_if.sv
//------------------------------------------------------------------------------
// maxpool_32_2_16_if
// Valid/ready stream bundle: sample input side and pooled-result output side.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface maxpool_32_2_16_if #(
    parameter int T = 16
);
    logic [T-1:0] x_data;
    logic         x_valid;
    logic         x_ready;
    logic [T-1:0] y_data;
    logic         y_valid;
    logic         y_ready;
    logic         y_last;

    // master drives samples in and consumes results; slave is the pooling block
    modport master (
        output x_data, x_valid, y_ready,
        input  x_ready, y_data, y_valid, y_last
    );

    modport slave (
        input  x_data, x_valid, y_ready,
        output x_ready, y_data, y_valid, y_last
    );
endinterface

`default_nettype wire

// File: rtl/maxpool_32_2_16.sv
//------------------------------------------------------------------------------
// maxpool_32_2_16
// Streaming 1-D max pooling (window/stride K over L-sample vectors), 2-deep output FIFO.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module maxpool_32_2_16 #(
    parameter int L = 32,
    parameter int K = 2,
    parameter int T = 16
) (
    input  logic               clk,
    input  logic               reset,
    maxpool_32_2_16_if.slave   bus
);

    localparam int EW = (L > 1) ? $clog2(L) : 1;
    localparam int WW = (K > 1) ? $clog2(K) : 1;

    localparam logic [EW-1:0] ELEM_LAST = EW'(L - 1);
    localparam logic [EW-1:0] ELEM_ONE  = EW'(1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(K - 1);
    localparam logic [WW-1:0] WIN_ONE   = WW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;

    logic [EW-1:0]        elem_cnt_q, elem_cnt_d;
    logic [WW-1:0]        win_cnt_q,  win_cnt_d;
    logic signed [T-1:0]  run_max_q,  run_max_d;
    logic [T:0]           mem_q [2];
    logic                 rd_ptr_q;
    logic                 wr_ptr_q;
    logic [1:0]           count_q;

    logic                 accept;
    logic                 pop;
    logic                 push;
    logic                 elem_end;
    logic                 win_end;
    logic                 win_first;
    logic signed [T-1:0]  x_s;
    logic signed [T-1:0]  cand;
    logic [1:0]           state_d;

    assign x_s       = $signed(bus.x_data);
    assign elem_end  = (elem_cnt_q == ELEM_LAST);
    assign win_end   = (win_cnt_q == WIN_LAST);
    assign win_first = (win_cnt_q == '0);

    // First sample of a window always loads, so an all-negative window never sees 0
    assign cand = (win_first || (x_s > run_max_q)) ? x_s : run_max_q;

    // Ready is withheld whenever the FIFO is full, even if it drains this cycle
    assign bus.x_ready = !reset && (count_q < 2'd2);
    assign accept      = bus.x_valid && bus.x_ready;
    assign pop         = (count_q != 2'd0) && bus.y_ready;

    assign bus.y_valid = (count_q != 2'd0);
    assign bus.y_data  = mem_q[rd_ptr_q][T-1:0];
    assign bus.y_last  = mem_q[rd_ptr_q][T];

    always_comb begin
        state_d    = S_IDLE;
        elem_cnt_d = elem_cnt_q;
        win_cnt_d  = win_cnt_q;
        run_max_d  = run_max_q;
        push       = 1'b0;

        if (accept) begin
            state_d = (win_end || elem_end) ? S_EMIT : S_ACCUM;
        end

        case (state_d)
            S_ACCUM: begin
                elem_cnt_d = elem_cnt_q + ELEM_ONE;
                win_cnt_d  = win_cnt_q + WIN_ONE;
                run_max_d  = cand;
            end
            S_EMIT: begin
                // A vector boundary also closes a short trailing window
                elem_cnt_d = elem_end ? '0 : (elem_cnt_q + ELEM_ONE);
                win_cnt_d  = '0;
                run_max_d  = cand;
                push       = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elem_cnt_q <= '0;
            win_cnt_q  <= '0;
            run_max_q  <= '0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            elem_cnt_q <= elem_cnt_d;
            win_cnt_q  <= win_cnt_d;
            run_max_q  <= run_max_d;

            if (push) begin
                mem_q[wr_ptr_q] <= {elem_end, cand};
                wr_ptr_q        <= ~wr_ptr_q;
            end

            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_maxpool_32_2_16.sv
//------------------------------------------------------------------------------
// tb_maxpool_32_2_16
// Directed and randomized stimulus against a window-list reference model.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_maxpool_32_2_16;

    localparam int LA = 32;
    localparam int KA = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int total = 0;
    int bad   = 0;

    maxpool_32_2_16_if #(.T(16)) if0 ();
    maxpool_32_2_16_if #(.T(16)) if5 ();

    maxpool_32_2_16 #(.L(32), .K(2), .T(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    maxpool_32_2_16 #(.L(5), .K(2), .T(16)) u_dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (if5.slave)
    );

    always #5 clk = ~clk;

    // Reference model: collect each window's samples, emit their maximum when
    // the window holds K samples or the vector runs out.
    logic signed [15:0] win_q [$];
    logic [16:0]        expq  [$];
    logic [16:0]        obs   [$];
    int                 eidx = 0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_accept(input logic [15:0] x);
        logic signed [15:0] m;
        win_q.push_back($signed(x));
        eidx++;
        if (win_q.size() == KA || eidx == LA) begin
            m = win_q[0];
            foreach (win_q[j]) if (win_q[j] > m) m = win_q[j];
            expq.push_back({(eidx == LA), m});
            win_q.delete();
            if (eidx == LA) eidx = 0;
        end
    endtask

    function automatic logic [16:0] obs_at(input int i);
        return (i < obs.size()) ? obs[i] : 17'h1ffff;
    endfunction

    // One clock cycle on the L=32 instance; entered and left just after a falling edge
    task automatic cyc(input logic xv, input logic [15:0] xd, input logic yr, output logic acc);
        logic [16:0] e;
        logic [16:0] got;
        if0.x_valid = xv;
        if0.x_data  = xd;
        if0.y_ready = yr;
        #1;
        acc = xv && if0.x_ready;
        if (if0.y_valid && yr) begin
            got = {if0.y_last, if0.y_data};
            obs.push_back(got);
            if (expq.size() == 0) begin
                chk("unexpected_pop", got, 17'h1ffff);
            end else begin
                e = expq.pop_front();
                chk("pop_data", got, e);
            end
        end
        if (acc) model_accept(xd);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int n, input int pv, input int pr);
        int   sent  = 0;
        int   guard = 0;
        logic a;
        while (sent < n && guard < n * 40) begin
            cyc(($urandom_range(99) < pv), 16'($urandom), ($urandom_range(99) < pr), a);
            if (a) sent++;
            guard++;
        end
        chk("send_budget", sent, n);
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 10 && expq.size() != 0; i++) cyc(1'b0, 16'h0, 1'b1, a);
        chk("drain_empty", expq.size(), 0);
        chk("drain_y_valid", if0.y_valid, 0);
    endtask

    initial begin
        logic        a;
        int          base;
        int          nlast;
        logic [15:0] v5  [10];
        logic [16:0] e5  [6];
        logic [15:0] sg  [6];
        logic [16:0] got5 [$];

        if0.x_valid = 1'b0; if0.x_data = '0; if0.y_ready = 1'b0;
        if5.x_valid = 1'b0; if5.x_data = '0; if5.y_ready = 1'b0;

        #1 reset = 1'b1;
        #3;
        chk("rst_x_ready",  if0.x_ready, 0);
        chk("rst_y_valid",  if0.y_valid, 0);
        chk("rst_y_data",   if0.y_data,  0);
        chk("rst_y_last",   if0.y_last,  0);
        chk("rst5_x_ready", if5.x_ready, 0);
        chk("rst5_y_valid", if5.y_valid, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_x_ready", if0.x_ready, 1);

        // L=5 partial trailing window, two back-to-back vectors
        v5 = '{16'd4, 16'd9, 16'd2, 16'd7, 16'd6, 16'd1, 16'd1, 16'd1, 16'd1, 16'd8};
        e5 = '{17'h00009, 17'h00007, 17'h10006, 17'h00001, 17'h00001, 17'h10008};
        if5.y_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if5.x_valid = (i < 10);
            if5.x_data  = (i < 10) ? v5[i] : 16'h0;
            #1;
            if (i < 10) chk("l5_x_ready", if5.x_ready, 1);
            if (if5.y_valid) got5.push_back({if5.y_last, if5.y_data});
            @(posedge clk);
            @(negedge clk);
        end
        if5.x_valid = 1'b0;
        if5.y_ready = 1'b0;
        chk("l5_count", got5.size(), 6);
        for (int i = 0; i < 6; i++) chk("l5_out", (i < got5.size()) ? got5[i] : 17'h1ffff, e5[i]);

        // Ramp 0..31 with the consumer always ready
        base = obs.size();
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 16'(i), 1'b1, a);
            chk("ramp_acc", a, 1);
            if (i == 0) chk("ramp_lat0", if0.y_valid, 0);
            if (i == 1) chk("ramp_lat1", {if0.y_valid, if0.y_data}, {1'b1, 16'd1});
        end
        drain();
        for (int j = 0; j < 16; j++) chk("ramp_out", obs_at(base + j), {(j == 15), 16'(2 * j + 1)});

        // Signed windows: (-5,-3) (0x8000,0x7FFF) (-1,0)
        sg = '{16'hFFFB, 16'hFFFD, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
        base = obs.size();
        for (int i = 0; i < 6; i++) cyc(1'b1, sg[i], 1'b1, a);
        send(26, 100, 100);
        drain();
        chk("sgn_out0", obs_at(base),     17'h0FFFD);
        chk("sgn_out1", obs_at(base + 1), 17'h07FFF);
        chk("sgn_out2", obs_at(base + 2), 17'h00000);

        // Back-pressure: fill the FIFO, then release a single pop
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 16'(100 + i), 1'b0, a);
            chk("bp_acc", a, 1);
        end
        chk("bp_x_ready_low", if0.x_ready, 0);
        chk("bp_y_valid",     if0.y_valid, 1);
        cyc(1'b1, 16'd104, 1'b0, a);
        chk("bp_stall", a, 0);
        cyc(1'b1, 16'd104, 1'b1, a);
        chk("bp_pop_cycle", a, 0);
        chk("bp_x_ready_back", if0.x_ready, 1);
        send(28, 100, 50);
        drain();

        // Asynchronous reset with one FIFO entry and a half-filled window
        cyc(1'b1, 16'h0123, 1'b0, a);
        cyc(1'b1, 16'h0456, 1'b0, a);
        cyc(1'b1, 16'h7000, 1'b0, a);
        chk("pre_rst_y_valid", if0.y_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_y_valid", if0.y_valid, 0);
        chk("mid_rst_x_ready", if0.x_ready, 0);
        chk("mid_rst_y_data",  if0.y_data,  0);
        expq.delete();
        win_q.delete();
        eidx = 0;
        @(negedge clk);
        reset = 1'b0;
        base = obs.size();
        cyc(1'b1, 16'd10, 1'b1, a);
        cyc(1'b1, 16'd20, 1'b1, a);
        drain();
        chk("post_rst_n",   obs.size() - base, 1);
        chk("post_rst_out", obs_at(base), 17'h00014);
        send(30, 100, 100);
        drain();

        // Ten vectors with 50% valid and 50% ready
        base = obs.size();
        send(320, 50, 50);
        drain();
        nlast = 0;
        for (int j = base; j < obs.size(); j++) if (obs[j][16]) nlast++;
        chk("rand_outs",  obs.size() - base, 160);
        chk("rand_lasts", nlast, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
